// File: rtl/uart_tx.sv
// uart_tx: UART transmitter. Sends a start bit, 8 data bits LSB first, an
// optional parity bit and a stop bit. Each bit lasts prescale_eff clock cycles.
// Optional macro UART_TX_HOLD_EN adds a one-entry holding register, so a word
// offered mid-frame is queued instead of dropped. It also adds the hold_full output.
module uart_tx #(
  parameter int DATA_W     = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  TX_OUT,
  output logic                  busy
`ifdef UART_TX_HOLD_EN
  ,
  output logic                  hold_full
`endif
);

  localparam int BIT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [PRESCALE_W-1:0] presc_q;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_W-1:0]     data_q;
  logic                  par_en_q;
  logic                  par_typ_q;

  // Divisors of 0 or 1 cannot be split into a bit period, so they become 2.
  logic [PRESCALE_W-1:0] presc_in;
  assign presc_in = (prescale < PRESCALE_W'(2)) ? PRESCALE_W'(2) : prescale;

  logic last_edge;
  logic stop_end;
  logic parity_bit;
  assign last_edge  = (edge_cnt == presc_q - PRESCALE_W'(1));
  assign stop_end   = (state == STOP) && last_edge;
  assign parity_bit = par_typ_q ? ~^data_q : ^data_q;

  // Word launched at this edge: it comes from the inputs or from the holding register.
  logic                  launch;
  logic [DATA_W-1:0]     l_data;
  logic                  l_par_en;
  logic                  l_par_typ;
  logic [PRESCALE_W-1:0] l_presc;

`ifdef UART_TX_HOLD_EN
  logic [DATA_W-1:0]     hold_data;
  logic                  hold_par_en;
  logic                  hold_par_typ;
  logic [PRESCALE_W-1:0] hold_presc;
  logic                  launch_hold;
  logic                  hold_load;

  // At the end of STOP a held word takes priority, and a simultaneous new word refills the hold.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no latch can be inferred.
    launch_hold = stop_end && hold_full;
    launch      = ((state == IDLE) && DATA_VALID) || (stop_end && (hold_full || DATA_VALID));
    hold_load   = DATA_VALID && (state != IDLE) && (stop_end ? hold_full : !hold_full);
    l_data      = P_DATA;
    l_par_en    = PAR_EN;
    l_par_typ   = PAR_TYP;
    l_presc     = presc_in;
    if (launch_hold) begin
      l_data    = hold_data;
      l_par_en  = hold_par_en;
      l_par_typ = hold_par_typ;
      l_presc   = hold_presc;
    end
  end

  // Holding register: filled while a frame is in progress, emptied when its word launches.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full    <= 1'b0;
      hold_data    <= '0;
      hold_par_en  <= 1'b0;
      hold_par_typ <= 1'b0;
      hold_presc   <= '0;
    end else if (hold_load) begin
      hold_full    <= 1'b1;
      hold_data    <= P_DATA;
      hold_par_en  <= PAR_EN;
      hold_par_typ <= PAR_TYP;
      hold_presc   <= presc_in;
    end else if (launch_hold) begin
      hold_full    <= 1'b0;
    end
  end
`else
  // Without a holding register, words are taken only when idle or on the last stop cycle.
  always_comb begin
    launch    = DATA_VALID && ((state == IDLE) || stop_end);
    l_data    = P_DATA;
    l_par_en  = PAR_EN;
    l_par_typ = PAR_TYP;
    l_presc   = presc_in;
  end
`endif

  // Frame sequencer: the bit timer, the state and the registered line and busy outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    if (rst) begin
      state     <= IDLE;
      edge_cnt  <= '0;
      bit_cnt   <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      presc_q   <= '0;
      TX_OUT    <= 1'b1;
      busy      <= 1'b0;
    end else begin
      if (launch) begin
        data_q    <= l_data;
        par_en_q  <= l_par_en;
        par_typ_q <= l_par_typ;
        presc_q   <= l_presc;
      end

      if (state == IDLE) begin
        if (launch) begin
          state    <= START;
          edge_cnt <= '0;
          TX_OUT   <= 1'b0;
          busy     <= 1'b1;
        end
      end else if (!last_edge) begin
        edge_cnt <= edge_cnt + PRESCALE_W'(1);
      end else begin
        edge_cnt <= '0;
        case (state)
          START: begin
            state   <= DATA;
            bit_cnt <= '0;
            TX_OUT  <= data_q[0];
          end
          DATA: begin
            if (bit_cnt != BIT_W'(DATA_W - 1)) begin
              bit_cnt <= bit_cnt + BIT_W'(1);
              TX_OUT  <= data_q[bit_cnt + BIT_W'(1)];
            end else if (par_en_q) begin
              state  <= PARITY;
              TX_OUT <= parity_bit;
            end else begin
              state  <= STOP;
              TX_OUT <= 1'b1;
            end
          end
          PARITY: begin
            state  <= STOP;
            TX_OUT <= 1'b1;
          end
          STOP: begin
            if (launch) begin
              state  <= START;
              TX_OUT <= 1'b0;
            end else begin
              state  <= IDLE;
              TX_OUT <= 1'b1;
              busy   <= 1'b0;
            end
          end
          default: begin
            state  <= IDLE;
            TX_OUT <= 1'b1;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx. Inputs are driven and outputs are
// sampled on the falling clock edge. Expected frames are written out by hand
// as {stop, [parity,] data, start}, with bit 0 sent first.
module tb_uart_tx;

  logic       clk;
  logic       rst;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] prescale;
  logic       TX_OUT;
  logic       busy;
`ifdef UART_TX_HOLD_EN
  logic       hold_full;
`endif

  int total = 0;
  int bad   = 0;

  uart_tx dut (
    .clk        (clk),
    .rst        (rst),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .prescale   (prescale),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
`ifdef UART_TX_HOLD_EN
    ,
    .hold_full  (hold_full)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Presents one word for a single acceptance edge and returns at frame cycle 0.
  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    prescale   = ps;
    DATA_VALID = 1'b1;
    @(negedge clk);
    DATA_VALID = 1'b0;
  endtask

  // Checks every cycle of a frame, starting at its cycle 0. It can inject a word at cycle inj.
  // inj = -1 drops DATA_VALID at cycle 0. inj = -2 leaves DATA_VALID untouched.
  task automatic expect_frame(input string tag, input logic [10:0] frame, input int nbits,
                              input int p, input int inj, input logic [7:0] inj_data);
    for (int i = 0; i < nbits * p; i++) begin
      if (i > 0) @(negedge clk);
      if (i == inj + 1) begin
        DATA_VALID = 1'b0;
`ifdef UART_TX_HOLD_EN
        if (inj >= 0) check($sformatf("%s hold_full", tag), hold_full, 1);
`endif
      end
      check($sformatf("%s tx c%0d", tag, i), TX_OUT, frame[i / p]);
      check($sformatf("%s busy c%0d", tag, i), busy, 1);
      if (i == inj) begin
        P_DATA     = inj_data;
        DATA_VALID = 1'b1;
      end
    end
  endtask

  task automatic expect_idle(input string tag);
    check($sformatf("%s idle tx", tag), TX_OUT, 1);
    check($sformatf("%s idle busy", tag), busy, 0);
  endtask

  // A mid-bit sampling receiver used for the loopback check. It starts at frame cycle 0.
  task automatic rx_capture(input string tag, input int p, output logic [7:0] d,
                            output logic perr, output logic serr);
    logic [10:0] s;
    int          n;
    s = '0;
    repeat (p / 2) @(negedge clk);
    for (int k = 0; k < 11; k++) begin
      if (k > 0) repeat (p) @(negedge clk);
      s[k] = TX_OUT;
    end
    check($sformatf("%s rx start", tag), s[0], 0);
    d    = s[8:1];
    perr = ~(^s[9:1]);
    serr = ~s[10];
    n = 0;
    while (busy && n < 64) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("%s busy_timeout", tag), busy, 0);
  endtask

  logic [7:0] rx_d;
  logic       rx_perr;
  logic       rx_serr;
  logic [7:0] lb_words [3];

  initial begin
    rst        = 1'b1;
    P_DATA     = 8'h00;
    DATA_VALID = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    prescale   = 6'd8;
    repeat (3) @(negedge clk);
    expect_idle("reset");
`ifdef UART_TX_HOLD_EN
    check("reset hold_full", hold_full, 0);
`endif
    rst = 1'b0;
    @(negedge clk);
    expect_idle("pre t1");

    // 1: A5, no parity, prescale 8 -> 0,1,0,1,0,0,1,0,1,1
    send(8'hA5, 1'b0, 1'b0, 6'd8);
    expect_frame("t1", {1'b0, 10'b1_1010_0101_0}, 10, 8, -1, 8'h00);
    @(negedge clk);
    expect_idle("t1 end");

    // 2: 07 has three ones: even parity bit 1, odd parity bit 0, 176 cycles
    send(8'h07, 1'b1, 1'b0, 6'd16);
    expect_frame("t2e", {1'b1, 1'b1, 8'h07, 1'b0}, 11, 16, -1, 8'h00);
    @(negedge clk);
    expect_idle("t2e end");
    send(8'h07, 1'b1, 1'b1, 6'd16);
    expect_frame("t2o", {1'b1, 1'b0, 8'h07, 1'b0}, 11, 16, -1, 8'h00);
    @(negedge clk);
    expect_idle("t2o end");

    // 3: DATA_VALID held high gives back-to-back frames with no idle gap
    P_DATA     = 8'h55;
    PAR_EN     = 1'b0;
    prescale   = 6'd8;
    DATA_VALID = 1'b1;
    @(negedge clk);
    P_DATA = 8'hAA;
    expect_frame("t3a", {1'b0, 1'b1, 8'h55, 1'b0}, 10, 8, -2, 8'h00);
    @(negedge clk);
    expect_frame("t3b", {1'b0, 1'b1, 8'hAA, 1'b0}, 10, 8, -1, 8'h00);
`ifdef UART_TX_HOLD_EN
    @(negedge clk);
    expect_frame("t3c", {1'b0, 1'b1, 8'hAA, 1'b0}, 10, 8, -1, 8'h00);
`endif
    @(negedge clk);
    expect_idle("t3 end");

    // 4: reset during data bit 4 (frame cycles 20..23 at prescale 4)
    send(8'hA5, 1'b0, 1'b0, 6'd4);
    repeat (21) @(negedge clk);
    check("t4 bit4", TX_OUT, 0);
    rst        = 1'b1;
    DATA_VALID = 1'b1;
    P_DATA     = 8'hFF;
    @(negedge clk);
    expect_idle("t4 rst");
    rst        = 1'b0;
    DATA_VALID = 1'b0;
    @(negedge clk);
    expect_idle("t4 post");
    send(8'h3C, 1'b0, 1'b0, 6'd4);
    expect_frame("t4", {1'b0, 1'b1, 8'h3C, 1'b0}, 10, 4, -1, 8'h00);
    @(negedge clk);
    expect_idle("t4 end");

    // 5: prescale 1 is clamped to 2. A word offered mid-frame is dropped, or held.
    send(8'h96, 1'b0, 1'b0, 6'd1);
    expect_frame("t5", {1'b0, 1'b1, 8'h96, 1'b0}, 10, 2, 5, 8'h11);
    @(negedge clk);
`ifdef UART_TX_HOLD_EN
    expect_frame("t5h", {1'b0, 1'b1, 8'h11, 1'b0}, 10, 2, -1, 8'h00);
    @(negedge clk);
    check("t5 hold_full end", hold_full, 0);
`endif
    expect_idle("t5 end");

    // 6: loopback into a receiver model, odd parity, prescale 8
    lb_words[0] = 8'h00;
    lb_words[1] = 8'hFF;
    lb_words[2] = 8'h3C;
    for (int w = 0; w < 3; w++) begin
      send(lb_words[w], 1'b1, 1'b1, 6'd8);
      rx_capture($sformatf("t6 w%0d", w), 8, rx_d, rx_perr, rx_serr);
      check($sformatf("t6 w%0d data", w), rx_d, lb_words[w]);
      check($sformatf("t6 w%0d parity_error", w), rx_perr, 0);
      check($sformatf("t6 w%0d stop_error", w), rx_serr, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
